// File: rtl/amaster_mm.sv
// rtl/amaster_mm.sv - Avalon-MM command master with command FIFO and waitrequest timeout
module amaster_mm #(
   parameter int ADDRW      = 8,
   parameter int DATAW      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [ADDRW-1:0] cmd_addr,
   input  logic [DATAW-1:0] cmd_wdata,
   output logic             rsp_valid,
   output logic             rsp_write,
   output logic [DATAW-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             busy,
   output logic [ADDRW-1:0] am_addr,
   output logic             am_read,
   output logic             am_write,
   output logic [DATAW-1:0] am_writedata,
   input  logic [DATAW-1:0] am_readdata,
   input  logic             am_waitrequest
);

   localparam int            PW         = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FIFO_DEPTH);
   localparam logic [7:0]    TIMEOUT_M1 = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                  state;
   logic [7:0]              wcnt;

   logic [ADDRW-1:0]        fifo_addr  [FIFO_DEPTH];
   logic [DATAW-1:0]        fifo_wdata [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_write;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [PW:0]             count;

   logic                    full;
   logic                    push;
   logic                    pop;

   assign full      = (count == FULL_CNT);
   assign cmd_ready = !full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign busy      = (count != '0) || (state != IDLE);

   // Command storage; entries need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr]  <= cmd_addr;
         fifo_wdata[wr_ptr] <= cmd_wdata;
         fifo_write[wr_ptr] <= cmd_write;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Transfer FSM: pop, hold request through waitrequest or abort on timeout, pulse response
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wcnt         <= '0;
         am_addr      <= '0;
         am_read      <= 1'b0;
         am_write     <= 1'b0;
         am_writedata <= '0;
         rsp_valid    <= 1'b0;
         rsp_write    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  am_addr      <= fifo_addr[rd_ptr];
                  am_writedata <= fifo_wdata[rd_ptr];
                  am_write     <= fifo_write[rd_ptr];
                  am_read      <= !fifo_write[rd_ptr];
                  wcnt         <= '0;
                  state        <= ISSUE;
               end else begin
                  am_addr      <= '0;
                  am_writedata <= '0;
                  am_write     <= 1'b0;
                  am_read      <= 1'b0;
               end
            end
            ISSUE: begin
               if (!am_waitrequest) begin
                  rsp_rdata <= am_read ? am_readdata : '0;
                  rsp_err   <= 1'b0;
                  rsp_write <= am_write;
                  rsp_valid <= 1'b1;
                  am_read   <= 1'b0;
                  am_write  <= 1'b0;
                  state     <= RESP;
               end else if (wcnt == TIMEOUT_M1) begin
                  // Slave stalled too long: abandon the transfer so the queue keeps moving
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_write <= am_write;
                  rsp_valid <= 1'b1;
                  am_read   <= 1'b0;
                  am_write  <= 1'b0;
                  state     <= RESP;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_amaster_mm.sv
// tb/tb_amaster_mm.sv - directed self-checking bench for amaster_mm
module tb_amaster_mm;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [7:0]  am_addr;
   logic        am_read;
   logic        am_write;
   logic [31:0] am_writedata;
   logic [31:0] am_readdata;
   logic        wait_req;

   logic        c1_valid;
   logic        c1_ready;
   logic        c1_write;
   logic [7:0]  c1_addr;
   logic [31:0] c1_wdata;
   logic        r1_valid;
   logic        r1_write;
   logic [31:0] r1_rdata;
   logic        r1_err;
   logic        b1_busy;
   logic [7:0]  a1_addr;
   logic        a1_read;
   logic        a1_write;
   logic [31:0] a1_writedata;
   logic [31:0] a1_readdata;
   logic        a1_wait;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int e;
   int accepts;
   int cnt;
   int guard;
   logic acc;

   logic [31:0] mem [256];
   logic [255:0] vld;

   bit          rq_write [$];
   logic [31:0] rq_data  [$];
   bit          rq_err   [$];
   int          rq_cyc   [$];

   always #5 clk = ~clk;

   amaster_mm #(.ADDRW(8), .DATAW(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .am_addr(am_addr), .am_read(am_read), .am_write(am_write),
      .am_writedata(am_writedata), .am_readdata(am_readdata),
      .am_waitrequest(wait_req)
   );

   amaster_mm #(.ADDRW(8), .DATAW(32), .FIFO_DEPTH(4), .TIMEOUT(1)) dut1 (
      .clk(clk), .rst(rst),
      .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_write(c1_write),
      .cmd_addr(c1_addr), .cmd_wdata(c1_wdata),
      .rsp_valid(r1_valid), .rsp_write(r1_write), .rsp_rdata(r1_rdata),
      .rsp_err(r1_err), .busy(b1_busy),
      .am_addr(a1_addr), .am_read(a1_read), .am_write(a1_write),
      .am_writedata(a1_writedata), .am_readdata(a1_readdata),
      .am_waitrequest(a1_wait)
   );

   assign a1_readdata = 32'h0;
   assign am_readdata = vld[am_addr] ? mem[am_addr] : {24'hA5A5A5, am_addr};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst) vld <= '0;
      else if (am_write && !wait_req) begin
         mem[am_addr] <= am_writedata;
         vld[am_addr] <= 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rsp_valid) begin
         rq_write.push_back(rsp_write);
         rq_data.push_back(rsp_rdata);
         rq_err.push_back(rsp_err);
         rq_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rsp();
      rq_write.delete();
      rq_data.delete();
      rq_err.delete();
      rq_cyc.delete();
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int g = 0;
      while (rq_data.size() < n && g < budget) begin
         tick();
         g++;
      end
      check_eq("rsp_count", rq_data.size(), n);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      wait_req = 1'b0;
      c1_valid = 1'b0; c1_write = 1'b0; c1_addr = '0; c1_wdata = '0; a1_wait = 1'b1;
      tick(); tick();
      check_eq("rst_cmd_ready", cmd_ready, 0);
      check_eq("rst_am_read", am_read, 0);
      check_eq("rst_am_write", am_write, 0);
      check_eq("rst_am_addr", am_addr, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_rdata", rsp_rdata, 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_cmd_ready", cmd_ready, 1);

      // TIMEOUT=1 instance: a single waitrequest-high edge aborts
      c1_valid = 1'b1; c1_addr = 8'h55;
      tick();
      c1_valid = 1'b0;
      tick();
      check_eq("t1_read_issued", a1_read, 1);
      tick();
      check_eq("t1_read_dropped", a1_read, 0);
      check_eq("t1_rsp_valid", r1_valid, 1);
      check_eq("t1_rsp_err", r1_err, 1);
      check_eq("t1_rsp_rdata", r1_rdata, 0);

      // Write then read, zero wait states; second push coincides with pop of the first
      clear_rsp();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
      tick();
      e = cyc;
      cmd_write = 1'b0; cmd_wdata = 32'h0;
      tick();
      check_eq("wr_am_write", am_write, 1);
      check_eq("wr_am_addr", am_addr, 8'h10);
      check_eq("wr_am_wdata", am_writedata, 32'hDEADBEEF);
      check_eq("pushpop_count", dut.count, 1);
      cmd_valid = 1'b0;
      wait_rsp(2, 20);
      check_eq("wr_rsp_write", rq_write[0], 1);
      check_eq("wr_rsp_rdata", rq_data[0], 0);
      check_eq("wr_rsp_err", rq_err[0], 0);
      check_eq("wr_rsp_latency", rq_cyc[0] - e, 2);
      check_eq("rd_rsp_write", rq_write[1], 0);
      check_eq("rd_rsp_rdata", rq_data[1], 32'hDEADBEEF);
      check_eq("rd_rsp_err", rq_err[1], 0);
      check_eq("rd_rsp_latency", rq_cyc[1] - e, 5);
      tick();
      check_eq("idle_busy", busy, 0);

      // Read with 5 wait-state edges
      clear_rsp();
      wait_req = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
      tick();
      e = cyc;
      cmd_valid = 1'b0;
      tick();
      check_eq("ws_am_read", am_read, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("ws_read_stable", am_read, 1);
         check_eq("ws_addr_stable", am_addr, 8'h04);
      end
      wait_req = 1'b0;
      wait_rsp(1, 20);
      check_eq("ws_rsp_latency", rq_cyc[0] - e, 7);
      check_eq("ws_rsp_rdata", rq_data[0], 32'hA5A5A504);
      check_eq("ws_rsp_err", rq_err[0], 0);

      // Timeout with a second command queued behind the stalled read
      clear_rsp();
      wait_req = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
      tick();
      e = cyc;
      cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'hCAFEF00D;
      tick();
      cmd_valid = 1'b0; cmd_write = 1'b0;
      cnt = 0; guard = 0;
      while (am_read && guard < 40) begin
         cnt++;
         guard++;
         tick();
      end
      check_eq("to_read_cycles", cnt, 16);
      check_eq("to_rsp_valid", rsp_valid, 1);
      check_eq("to_rsp_err", rsp_err, 1);
      check_eq("to_rsp_rdata", rsp_rdata, 0);
      check_eq("to_rsp_cycle", cyc - e, 17);
      wait_req = 1'b0;
      wait_rsp(2, 20);
      check_eq("to_next_write", rq_write[1], 1);
      check_eq("to_next_err", rq_err[1], 0);
      check_eq("to_next_latency", rq_cyc[1] - e, 20);

      // FIFO full and ordering: 1 in flight plus 4 queued
      clear_rsp();
      wait_req = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
      accepts = 0;
      for (int k = 0; k < 8; k++) begin
         acc = cmd_ready;
         tick();
         if (acc) begin
            accepts++;
            cmd_addr = 8'h30 + 8'(accepts);
         end
      end
      check_eq("full_accepts", accepts, 5);
      check_eq("full_cmd_ready", cmd_ready, 0);
      wait_req = 1'b0;
      guard = 0;
      while (accepts < 6 && guard < 50) begin
         acc = cmd_ready;
         tick();
         guard++;
         if (acc) begin
            accepts++;
            cmd_addr = 8'h30 + 8'(accepts);
         end
      end
      cmd_valid = 1'b0;
      check_eq("full_total_accepts", accepts, 6);
      wait_rsp(6, 100);
      for (int i = 0; i < 6; i++) begin
         check_eq("order_rdata", rq_data[i], 32'hA5A5A530 + 32'(i));
         check_eq("order_err", rq_err[i], 0);
      end

      // Reset during ISSUE with two commands still queued
      tick();
      clear_rsp();
      wait_req = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmd_addr = 8'h40 + 8'(i);
         tick();
      end
      cmd_valid = 1'b0;
      tick();
      check_eq("mid_am_read", am_read, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_am_read", am_read, 0);
      check_eq("mid_rst_am_write", am_write, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_rsp_valid", rsp_valid, 0);
      wait_req = 1'b0;
      repeat (20) tick();
      check_eq("mid_rst_no_rsp", rq_data.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
